// File: rtl/project_register_file.sv
// PWM configuration register file: 15 byte registers at addresses 0-14 with a zero-cycle read port.
// Define PWM1B_CHANNEL_EN to implement the PWM1B channel registers (addresses 9-14).
module project_register_file (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_write_en,
  input  logic [5:0] i_address,
  input  logic [7:0] i_data,
  output logic [7:0] o_data,
  output logic [7:0] o_pwm1_control_register,
  output logic [7:0] o_pwm1_msb_period,
  output logic [7:0] o_pwm1_lsb_period,
  output logic [7:0] o_pwm1A_action_register,
  output logic [7:0] o_pwm1A_msb_compa,
  output logic [7:0] o_pwm1A_lsb_compa,
  output logic [7:0] o_pwm1A_msb_compb,
  output logic [7:0] o_pwm1A_lsb_compb,
  output logic [7:0] o_pwm1A_deadband_register,
  output logic [7:0] o_pwm1B_action_register,
  output logic [7:0] o_pwm1B_msb_compa,
  output logic [7:0] o_pwm1B_lsb_compa,
  output logic [7:0] o_pwm1B_msb_compb,
  output logic [7:0] o_pwm1B_lsb_compb,
  output logic [7:0] o_pwm1B_deadband_register
);

`ifdef PWM1B_CHANNEL_EN
  localparam int NUM_IMPL = 15;
`else
  localparam int NUM_IMPL = 9;
`endif

  logic [7:0] regs_q [NUM_IMPL];
  logic [7:0] regs_d [NUM_IMPL];
  logic [7:0] rd_data_s;

  // Next-state: at most one implemented register takes i_data; unmapped addresses match nothing
  always_comb begin
    for (int i = 0; i < NUM_IMPL; i++) begin
      if (i_write_en && (i_address == 6'(i))) begin
        regs_d[i] = i_data;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // Register storage, cleared asynchronously while i_reset is low
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < NUM_IMPL; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < NUM_IMPL; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read mux: anything outside the implemented range reads as zero
  always_comb begin
    rd_data_s = 8'h00;
    for (int i = 0; i < NUM_IMPL; i++) begin
      if (i_address == 6'(i)) begin
        rd_data_s = regs_q[i];
      end else begin
        rd_data_s = rd_data_s;
      end
    end
  end

  assign o_data                    = rd_data_s;
  assign o_pwm1_control_register   = regs_q[0];
  assign o_pwm1_msb_period         = regs_q[1];
  assign o_pwm1_lsb_period         = regs_q[2];
  assign o_pwm1A_action_register   = regs_q[3];
  assign o_pwm1A_msb_compa         = regs_q[4];
  assign o_pwm1A_lsb_compa         = regs_q[5];
  assign o_pwm1A_msb_compb         = regs_q[6];
  assign o_pwm1A_lsb_compb         = regs_q[7];
  assign o_pwm1A_deadband_register = regs_q[8];

`ifdef PWM1B_CHANNEL_EN
  assign o_pwm1B_action_register   = regs_q[9];
  assign o_pwm1B_msb_compa         = regs_q[10];
  assign o_pwm1B_lsb_compa         = regs_q[11];
  assign o_pwm1B_msb_compb         = regs_q[12];
  assign o_pwm1B_lsb_compb         = regs_q[13];
  assign o_pwm1B_deadband_register = regs_q[14];
`else
  assign o_pwm1B_action_register   = 8'h00;
  assign o_pwm1B_msb_compa         = 8'h00;
  assign o_pwm1B_lsb_compa         = 8'h00;
  assign o_pwm1B_msb_compb         = 8'h00;
  assign o_pwm1B_lsb_compb         = 8'h00;
  assign o_pwm1B_deadband_register = 8'h00;
`endif

endmodule

// File: tb/tb_project_register_file.sv
// Self-checking bench for project_register_file: directed tables, corner sequences and a
// randomized run against a 64-entry memory model (honours PWM1B_CHANNEL_EN).
module tb_project_register_file;

  logic       i_clk;
  logic       i_reset;
  logic       i_write_en;
  logic [5:0] i_address;
  logic [7:0] i_data;
  logic [7:0] o_data;
  logic [7:0] outs [15];

  int checks = 0;
  int errors = 0;
  logic [7:0] model [64];

  typedef struct {
    logic [5:0] addr;
    logic [7:0] data;
  } vec_t;

  project_register_file dut (
    .i_clk                     (i_clk),
    .i_reset                   (i_reset),
    .i_write_en                (i_write_en),
    .i_address                 (i_address),
    .i_data                    (i_data),
    .o_data                    (o_data),
    .o_pwm1_control_register   (outs[0]),
    .o_pwm1_msb_period         (outs[1]),
    .o_pwm1_lsb_period         (outs[2]),
    .o_pwm1A_action_register   (outs[3]),
    .o_pwm1A_msb_compa         (outs[4]),
    .o_pwm1A_lsb_compa         (outs[5]),
    .o_pwm1A_msb_compb         (outs[6]),
    .o_pwm1A_lsb_compb         (outs[7]),
    .o_pwm1A_deadband_register (outs[8]),
    .o_pwm1B_action_register   (outs[9]),
    .o_pwm1B_msb_compa         (outs[10]),
    .o_pwm1B_lsb_compa         (outs[11]),
    .o_pwm1B_msb_compb         (outs[12]),
    .o_pwm1B_lsb_compb         (outs[13]),
    .o_pwm1B_deadband_register (outs[14])
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Which addresses hold storage in this build
  function automatic bit writable(input logic [5:0] a);
`ifdef PWM1B_CHANNEL_EN
    return a < 6'd15;
`else
    return a < 6'd9;
`endif
  endfunction

  task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] actual %h required %h", name, idx, act, exp);
    end
  endtask

  task automatic check_regs(input string name);
    for (int i = 0; i < 15; i++) check(name, i, outs[i], model[i]);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 64; i++) model[i] = 8'h00;
  endtask

  // One bus cycle from posedge+1: drive, check read of old value, clock, check new value
  task automatic do_cycle(input logic we, input logic [5:0] a, input logic [7:0] d, input string name);
    i_write_en = we;
    i_address  = a;
    i_data     = d;
    #1;
    check({name, "_pre"}, int'(a), o_data, model[a]);
    @(posedge i_clk);
    if (we && writable(a)) model[a] = d;
    #1;
    check({name, "_post"}, int'(a), o_data, model[a]);
  endtask

  vec_t wr_tab [8];
  vec_t rd_tab [10];
  logic [5:0] ra;

  initial begin
    clear_model();
    wr_tab[0] = '{6'd0, 8'h05}; wr_tab[1] = '{6'd1, 8'h01};
    wr_tab[2] = '{6'd2, 8'h80}; wr_tab[3] = '{6'd3, 8'h12};
    wr_tab[4] = '{6'd4, 8'h0A}; wr_tab[5] = '{6'd5, 8'h2A};
    wr_tab[6] = '{6'd6, 8'h80}; wr_tab[7] = '{6'd7, 8'h42};
    rd_tab[0] = '{6'd0, 8'h05}; rd_tab[1] = '{6'd1, 8'h01};
    rd_tab[2] = '{6'd2, 8'h80}; rd_tab[3] = '{6'd3, 8'h12};
    rd_tab[4] = '{6'd4, 8'h0A}; rd_tab[5] = '{6'd5, 8'h2A};
    rd_tab[6] = '{6'd6, 8'h80}; rd_tab[7] = '{6'd7, 8'h42};
    rd_tab[8] = '{6'd8, 8'h00}; rd_tab[9] = '{6'd9, 8'h00};

    // Reset held with writes requested: nothing may change
    i_reset = 1'b0; i_write_en = 1'b1; i_address = 6'd0; i_data = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      @(posedge i_clk); #1;
      i_address = 6'(c * 3);
    end
    check_regs("reset_out");
    check("reset_rd", int'(i_address), o_data, 8'h00);

    i_reset = 1'b1;
    for (int k = 0; k < 8; k++) do_cycle(1'b1, wr_tab[k].addr, wr_tab[k].data, "seq_wr");
    check_regs("seq_regs");

    i_write_en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      i_address = rd_tab[k].addr;
      #1;
      check("readback", k, o_data, rd_tab[k].data);
    end

    do_cycle(1'b1, 6'd15, 8'hAA, "unmapped15");
    do_cycle(1'b1, 6'd63, 8'hAA, "unmapped63");
    check_regs("unmapped_regs");

    // Configuration-dependent channel B register
    do_cycle(1'b1, 6'd9, 8'h5A, "cfg_wr9");
`ifdef PWM1B_CHANNEL_EN
    check("cfg_out9", 9, outs[9], 8'h5A);
`else
    check("cfg_out9", 9, outs[9], 8'h00);
`endif

    // Back-to-back writes to one address: last write wins
    do_cycle(1'b1, 6'd3, 8'h11, "b2b");
    do_cycle(1'b1, 6'd3, 8'h22, "b2b");
    do_cycle(1'b1, 6'd4, 8'h33, "b2b");
    check("b2b_out3", 3, outs[3], 8'h22);
    check("b2b_out4", 4, outs[4], 8'h33);

    for (int n = 0; n < 400; n++) begin
      ra = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 15));
      do_cycle(1'($urandom_range(0, 1)), ra, 8'($urandom), "rand");
      if (n % 25 == 0) check_regs("rand_regs");
    end
    check_regs("rand_final");

    // Asynchronous reset between edges, then writes ignored while low
    do_cycle(1'b1, 6'd1, 8'hC3, "pre_arst");
    i_write_en = 1'b0;
    #2;
    i_reset = 1'b0;
    #1;
    clear_model();
    check_regs("arst_regs");
    i_address = 6'd1;
    #1;
    check("arst_rd", 1, o_data, 8'h00);
    i_write_en = 1'b1; i_address = 6'd2; i_data = 8'h3C;
    @(posedge i_clk); #1;
    check_regs("arst_held");
    i_reset = 1'b1;
    do_cycle(1'b1, 6'd2, 8'h3C, "post_arst");
    check("post_arst_out2", 2, outs[2], 8'h3C);
    check_regs("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
